// File: rtl/dvp_rgb565_tx.sv
// -----------------------------------------------------------------------------
// dvp_rgb565_tx
// Source end of a byte-serial RGB565 DVP link (OV5640 stand-in). Generates
// frame/line timing (vsync, href) and serialises each 16-bit pixel as high
// byte then low byte. Pixels come from an internal test pattern or from an
// external request/response stream.
//
// Ports:
//   clk          byte clock (equals the DVP pixel clock)
//   rst_n        synchronous active-low reset
//   en           frame enable, level sensitive, checked in IDLE and on the
//                final front-porch cycle
//   pattern_sel  0 colour bars, 1 gradient, 2 solid pix_data, 3 external
//   pix_data     external RGB565 pixel (patterns 2 and 3)
//   pix_req      external pixel request, one cycle before each phase-0 byte
//   dvp_vsync    frame sync, high during VSYNC
//   dvp_href     line valid, high while dvp_data carries pixel bytes
//   dvp_data     byte-serial RGB565 data, 0 outside active lines
//   frame_done   one-cycle pulse on the final front-porch cycle
//   busy         high in every state except IDLE
//
// Every output is a register loaded from the next-state values, so the state
// visible in a cycle and the outputs of that cycle always agree.
// -----------------------------------------------------------------------------
module dvp_rgb565_tx #(
    parameter int H_PIXEL   = 1024,
    parameter int V_PIXEL   = 768,
    parameter int VSYNC_LEN = 4,
    parameter int V_BP      = 16,
    parameter int H_BLANK   = 64,
    parameter int V_FP      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] pix_data,
    output logic        pix_req,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        busy
);

    // Terminal counts of the timers and pixel/line counters.
    localparam logic [15:0] VSYNC_LAST_C = 16'(VSYNC_LEN - 1);
    localparam logic [15:0] VBP_LAST_C   = 16'(V_BP - 1);
    localparam logic [15:0] HBLANK_LAST_C = 16'(H_BLANK - 1);
    localparam logic [15:0] VFP_LAST_C   = 16'(V_FP - 1);
    localparam logic [15:0] X_LAST_C     = 16'(H_PIXEL - 1);
    localparam logic [15:0] Y_LAST_C     = 16'(V_PIXEL - 1);
    localparam logic [15:0] BAR_LAST_C   = 16'((H_PIXEL / 8) - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFP    = 3'd5
    } state_t;

    // Colour-bar palette, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            3'd7:    c = 16'h0000;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Gradient: x in red and blue, y in green.
    function automatic logic [15:0] gradient(input logic [4:0] x_lo, input logic [5:0] y_lo);
        return {x_lo, y_lo, x_lo};
    endfunction

    // Registered state.
    state_t      state_r;
    logic [15:0] timer_r;
    logic [15:0] x_cnt_r;
    logic [15:0] y_cnt_r;
    logic        phase_r;
    logic [15:0] bar_cnt_r;
    logic [2:0]  bar_idx_r;
    logic [1:0]  pat_q_r;
    logic [7:0]  low_byte_r;

    // Registered outputs.
    logic        pix_req_r;
    logic        dvp_vsync_r;
    logic        dvp_href_r;
    logic [7:0]  dvp_data_r;
    logic        frame_done_r;
    logic        busy_r;

    // Next-state values.
    state_t      state_s;
    logic [15:0] timer_s;
    logic [15:0] x_cnt_s;
    logic [15:0] y_cnt_s;
    logic        phase_s;
    logic [15:0] bar_cnt_s;
    logic [2:0]  bar_idx_s;
    logic [1:0]  pat_s;
    logic        px_start_s;   // the coming edge starts phase 0 of a pixel
    logic [15:0] pixel_s;
    logic        req_s;

    // Next-state, timer and counter logic for the frame FSM.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        x_cnt_s    = x_cnt_r;
        y_cnt_s    = y_cnt_r;
        phase_s    = phase_r;
        bar_cnt_s  = bar_cnt_r;
        bar_idx_s  = bar_idx_r;
        pat_s      = pat_q_r;
        px_start_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_s = ST_VSYNC;
                    timer_s = 16'd0;
                    pat_s   = pattern_sel;
                    x_cnt_s = 16'd0;
                    y_cnt_s = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_VSYNC: begin
                if (timer_r == VSYNC_LAST_C) begin
                    state_s = ST_VBP;
                    timer_s = 16'd0;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end

            ST_VBP: begin
                if (timer_r == VBP_LAST_C) begin
                    state_s    = ST_LINE;
                    timer_s    = 16'd0;
                    x_cnt_s    = 16'd0;
                    y_cnt_s    = 16'd0;
                    phase_s    = 1'b0;
                    bar_cnt_s  = 16'd0;
                    bar_idx_s  = 3'd0;
                    px_start_s = 1'b1;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end

            ST_LINE: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else if (x_cnt_r == X_LAST_C) begin
                    state_s = ST_HBLANK;
                    timer_s = 16'd0;
                    phase_s = 1'b0;
                end else begin
                    x_cnt_s    = x_cnt_r + 16'd1;
                    phase_s    = 1'b0;
                    px_start_s = 1'b1;
                    // Bar counter replaces an x / (H_PIXEL/8) divider.
                    if (bar_cnt_r == BAR_LAST_C) begin
                        bar_cnt_s = 16'd0;
                        bar_idx_s = bar_idx_r + 3'd1;
                    end else begin
                        bar_cnt_s = bar_cnt_r + 16'd1;
                    end
                end
            end

            ST_HBLANK: begin
                if (timer_r == HBLANK_LAST_C) begin
                    if (y_cnt_r < Y_LAST_C) begin
                        state_s    = ST_LINE;
                        timer_s    = 16'd0;
                        y_cnt_s    = y_cnt_r + 16'd1;
                        x_cnt_s    = 16'd0;
                        phase_s    = 1'b0;
                        bar_cnt_s  = 16'd0;
                        bar_idx_s  = 3'd0;
                        px_start_s = 1'b1;
                    end else begin
                        state_s = ST_VFP;
                        timer_s = 16'd0;
                    end
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end

            ST_VFP: begin
                if (timer_r == VFP_LAST_C) begin
                    timer_s = 16'd0;
                    x_cnt_s = 16'd0;
                    y_cnt_s = 16'd0;
                    if (en) begin
                        state_s = ST_VSYNC;
                        pat_s   = pattern_sel;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                timer_s = 16'd0;
                x_cnt_s = 16'd0;
                y_cnt_s = 16'd0;
                phase_s = 1'b0;
            end
        endcase
    end

    // Pixel for the phase-0 cycle being entered, chosen by the latched pattern.
    always_comb begin
        pixel_s = 16'h0000;
        case (pat_s)
            2'd0:    pixel_s = bar_colour(bar_idx_s);
            2'd1:    pixel_s = gradient(x_cnt_s[4:0], y_cnt_s[5:0]);
            2'd2:    pixel_s = pix_data;
            2'd3:    pixel_s = pix_data;
            default: pixel_s = 16'h0000;
        endcase
    end

    // External request: high in the cycle that precedes every phase-0 cycle.
    always_comb begin
        req_s = 1'b0;
        if (pat_s != 2'd3) begin
            req_s = 1'b0;
        end else if ((state_s == ST_VBP) && (timer_s == VBP_LAST_C)) begin
            req_s = 1'b1;
        end else if ((state_s == ST_HBLANK) && (timer_s == HBLANK_LAST_C) &&
                     (y_cnt_s < Y_LAST_C)) begin
            req_s = 1'b1;
        end else if ((state_s == ST_LINE) && phase_s && (x_cnt_s < X_LAST_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            timer_r      <= 16'd0;
            x_cnt_r      <= 16'd0;
            y_cnt_r      <= 16'd0;
            phase_r      <= 1'b0;
            bar_cnt_r    <= 16'd0;
            bar_idx_r    <= 3'd0;
            pat_q_r      <= 2'd0;
            low_byte_r   <= 8'd0;
            pix_req_r    <= 1'b0;
            dvp_vsync_r  <= 1'b0;
            dvp_href_r   <= 1'b0;
            dvp_data_r   <= 8'd0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            x_cnt_r      <= x_cnt_s;
            y_cnt_r      <= y_cnt_s;
            phase_r      <= phase_s;
            bar_cnt_r    <= bar_cnt_s;
            bar_idx_r    <= bar_idx_s;
            pat_q_r      <= pat_s;
            pix_req_r    <= req_s;
            dvp_vsync_r  <= (state_s == ST_VSYNC);
            dvp_href_r   <= (state_s == ST_LINE);
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_s == ST_VFP) && (timer_s == VFP_LAST_C);
            // The whole pixel is captured at phase 0; the low byte waits a cycle.
            if (state_s == ST_LINE) begin
                if (px_start_s) begin
                    dvp_data_r <= pixel_s[15:8];
                    low_byte_r <= pixel_s[7:0];
                end else begin
                    dvp_data_r <= low_byte_r;
                end
            end else begin
                dvp_data_r <= 8'd0;
            end
        end
    end

    assign pix_req    = pix_req_r;
    assign dvp_vsync  = dvp_vsync_r;
    assign dvp_href   = dvp_href_r;
    assign dvp_data   = dvp_data_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// -----------------------------------------------------------------------------
// tb_dvp_rgb565_tx
// Directed bench for dvp_rgb565_tx with small timing parameters. Frames are
// recorded cycle by cycle, then compared against expectations computed from
// the frame geometry and the pattern definitions.
// -----------------------------------------------------------------------------
module tb_dvp_rgb565_tx;

    localparam int HP     = 8;
    localparam int VP     = 4;
    localparam int VSL    = 3;
    localparam int VBP    = 2;
    localparam int HB     = 4;
    localparam int VFP    = 2;
    localparam int LINE_T = 2 * HP + HB;                  // 20
    localparam int FIRST  = VSL + VBP;                    // 5
    localparam int FRAME  = VSL + VBP + VP * LINE_T + VFP; // 87

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [15:0] pix_data;
    logic        pix_req;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_done;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int req_k  = 0;

    logic        s_vs [0:127];
    logic        s_hr [0:127];
    logic        s_fd [0:127];
    logic        s_bz [0:127];
    logic        s_rq [0:127];
    logic [7:0]  s_d  [0:127];
    logic [15:0] bars [0:7];

    dvp_rgb565_tx #(
        .H_PIXEL   (HP),
        .V_PIXEL   (VP),
        .VSYNC_LEN (VSL),
        .V_BP      (VBP),
        .H_BLANK   (HB),
        .V_FP      (VFP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pattern_sel (pattern_sel),
        .pix_data    (pix_data),
        .pix_req     (pix_req),
        .dvp_vsync   (dvp_vsync),
        .dvp_href    (dvp_href),
        .dvp_data    (dvp_data),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    // Record n cycles at the falling edge; at cycle chg drop en and change
    // pattern_sel. The external source answers each request with A000+k.
    task automatic capture(input int n, input int chg, input logic [1:0] chg_pat);
        for (int i = 0; i < n; i++) begin
            if (i == chg) begin
                en          = 1'b0;
                pattern_sel = chg_pat;
            end
            @(negedge clk);
            s_vs[i] = dvp_vsync;
            s_hr[i] = dvp_href;
            s_fd[i] = frame_done;
            s_bz[i] = busy;
            s_rq[i] = pix_req;
            s_d[i]  = dvp_data;
            if (pix_req) begin
                pix_data = 16'hA000 + 16'(req_k);
                req_k++;
            end
        end
    endtask

    function automatic logic [15:0] exp_pix(input int pat, input int line, input int px, input logic [15:0] solid);
        logic [15:0] p;
        case (pat)
            0:       p = bars[px / (HP / 8)];
            1:       p = {px[4:0], line[5:0], px[4:0]};
            2:       p = solid;
            default: p = 16'hA000 + 16'(line * HP + px);
        endcase
        return p;
    endfunction

    // Compare the first n recorded cycles of a frame against the expected frame.
    task automatic check_frame(input int n, input int pat, input logic [15:0] solid);
        for (int i = 0; i < n; i++) begin
            int          t;
            int          line;
            int          pos;
            logic        ev;
            logic        eh;
            logic        erq;
            logic [7:0]  ed;
            logic [15:0] pix;
            t    = i - FIRST;
            line = t / LINE_T;
            pos  = t % LINE_T;
            ev   = (i < VSL);
            eh   = (t >= 0) && (line < VP) && (pos < 2 * HP);
            ed   = 8'h00;
            if (eh) begin
                pix = exp_pix(pat, line, pos / 2, solid);
                ed  = (pos % 2 == 1) ? pix[7:0] : pix[15:8];
            end
            erq = (pat == 3) &&
                  ((i == FIRST - 1) ||
                   ((t >= 0) && (line < VP - 1) && (pos == LINE_T - 1)) ||
                   (eh && (pos % 2 == 1) && (pos / 2 < HP - 1)));
            chk("vsync", i, 16'(s_vs[i]), 16'(ev));
            chk("href", i, 16'(s_hr[i]), 16'(eh));
            chk("data", i, 16'(s_d[i]), 16'(ed));
            chk("frame_done", i, 16'(s_fd[i]), 16'(i == FRAME - 1));
            chk("busy", i, 16'(s_bz[i]), 16'd1);
            chk("pix_req", i, 16'(s_rq[i]), 16'(erq));
        end
    endtask

    // All outputs must read zero for n cycles.
    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_vsync", i, 16'(dvp_vsync), 16'd0);
            chk("idle_href", i, 16'(dvp_href), 16'd0);
            chk("idle_data", i, 16'(dvp_data), 16'd0);
            chk("idle_done", i, 16'(frame_done), 16'd0);
            chk("idle_busy", i, 16'(busy), 16'd0);
            chk("idle_req", i, 16'(pix_req), 16'd0);
        end
    endtask

    initial begin
        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
        rst_n       = 1'b0;
        en          = 1'b0;
        pattern_sel = 2'd0;
        pix_data    = 16'h0000;

        // Reset state, then idle with en low.
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 16'(busy), 16'd0);
        chk("rst_vsync", 0, 16'(dvp_vsync), 16'd0);
        chk("rst_data", 0, 16'(dvp_data), 16'd0);
        rst_n = 1'b1;
        check_idle(3);

        // Frame A: colour bars, en held high.
        pattern_sel = 2'd0;
        en          = 1'b1;
        capture(FRAME, -1, 2'd0);
        check_frame(FRAME, 0, 16'h0000);

        // Frame B follows immediately; pattern_sel 0->1 and en dropped mid-frame.
        capture(FRAME, 30, 2'd1);
        check_frame(FRAME, 0, 16'h0000);
        check_idle(5);

        // Frame C: gradient.
        pattern_sel = 2'd1;
        en          = 1'b1;
        capture(FRAME, 40, 2'd1);
        check_frame(FRAME, 1, 16'h0000);
        chk("grad_l3p5_hi", 0, 16'(s_d[FIRST + 3 * LINE_T + 10]), 16'h0028);
        chk("grad_l3p5_lo", 0, 16'(s_d[FIRST + 3 * LINE_T + 11]), 16'h0065);
        check_idle(3);

        // Frame D: external stream.
        pattern_sel = 2'd3;
        en          = 1'b1;
        req_k       = 0;
        capture(FRAME, 40, 2'd3);
        check_frame(FRAME, 3, 16'h0000);
        chk("req_count", 0, 16'(req_k), 16'(VP * HP));
        chk("ext_first_byte", 0, 16'(s_d[FIRST]), 16'h00A0);
        chk("ext_last_byte", 0, 16'(s_d[FIRST + 15]), 16'h0007);
        check_idle(3);

        // Frame E: solid pix_data.
        pix_data    = 16'h5AC3;
        pattern_sel = 2'd2;
        en          = 1'b1;
        capture(FRAME, 40, 2'd2);
        check_frame(FRAME, 2, 16'h5AC3);
        check_idle(3);

        // Frame F: reset during line 2, byte 5, then a fresh frame.
        pattern_sel = 2'd0;
        en          = 1'b1;
        capture(50, -1, 2'd0);
        check_frame(50, 0, 16'h0000);
        @(negedge clk);
        chk("pre_rst_href", 0, 16'(dvp_href), 16'd1);
        chk("pre_rst_data", 0, 16'(dvp_data), 16'h00FF);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_href", 0, 16'(dvp_href), 16'd0);
        chk("mid_rst_data", 0, 16'(dvp_data), 16'd0);
        chk("mid_rst_done", 0, 16'(frame_done), 16'd0);
        chk("mid_rst_busy", 0, 16'(busy), 16'd0);
        chk("mid_rst_vsync", 0, 16'(dvp_vsync), 16'd0);
        @(negedge clk);
        chk("mid_rst_busy2", 1, 16'(busy), 16'd0);
        rst_n = 1'b1;
        capture(FRAME, -1, 2'd0);
        check_frame(FRAME, 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dvp_rgb565_tx.md
Name: dvp_rgb565_tx

Overview:
- DVP camera-interface transmitter: the source end of the byte-serial RGB565 link that the capture path receives (vsync / href / 8-bit data).
- Generates frame and line timing and serialises each 16-bit pixel as high byte then low byte.
- Pixel source is an internal test pattern or an external pixel stream.
- Used as an OV5640 stand-in for board bring-up and as the stimulus source for capture, colour-conversion and AE simulations.

Parameters:
- H_PIXEL, 1024, active pixels per line (must be a multiple of 8, ≥ 8).
- V_PIXEL, 768, active lines per frame (≥ 1).
- VSYNC_LEN, 4, cycles dvp_vsync is high per frame (≥ 1).
- V_BP, 16, cycles between vsync falling and first href of the frame (≥ 1).
- H_BLANK, 64, cycles href is low after each line (≥ 1).
- V_FP, 16, cycles after the last line's blanking before the frame ends (≥ 1).

Ports:
- clk  in  1  byte clock; equals the DVP pixel clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  frame enable; level-sensitive.
- pattern_sel  in  2  0 = colour bars, 1 = gradient, 2 = solid pix_data, 3 = external stream.
- pix_data  in  16  external RGB565 pixel, sampled as defined in Behaviour.
- pix_req  out  1  external pixel request.
- dvp_vsync  out  1  frame sync; high during the VSYNC state.
- dvp_href  out  1  line valid; high while data bytes are valid.
- dvp_data  out  8  byte-serial RGB565 data.
- frame_done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset:
  - Synchronous: when rst_n is low at a clk edge, the FSM goes to IDLE.
  - All outputs are 0 from that edge; all counters are cleared.
  - Reset mid-frame aborts the frame with no frame_done.
- Output timing:
  - All outputs are registered.
  - The FSM state visible at cycle n drives the outputs at cycle n.
- FSM states and transitions:
  - IDLE: if en=1, go to VSYNC and latch pattern_sel into pat_q. pat_q is held for the whole frame; pattern_sel changes mid-frame are ignored.
  - VSYNC: dvp_vsync=1 for VSYNC_LEN cycles, then VBP.
  - VBP: V_BP cycles, then LINE.
  - LINE: dvp_href=1 for exactly 2*H_PIXEL cycles, then HBLANK.
    - Phase 0: dvp_data = pixel[15:8]; phase 1: dvp_data = pixel[7:0].
    - x_cnt (0..H_PIXEL-1) increments after phase 1.
  - HBLANK: H_BLANK cycles.
    - If y_cnt < V_PIXEL-1: y_cnt++, x_cnt=0, go to LINE.
    - Otherwise go to VFP.
  - VFP: V_FP cycles. frame_done=1 on the final VFP cycle.
    - Next state is VSYNC (relatching pattern_sel) if en=1 on that cycle, else IDLE.
- en deasserted mid-frame: the current frame completes normally.
- Frame length: VSYNC_LEN + V_BP + V_PIXEL*(2*H_PIXEL + H_BLANK) + V_FP cycles.
- Outside LINE: dvp_data=0 and dvp_href=0.
- Pixel generation:
  - Pattern 0, colour bars: 8 bars, each H_PIXEL/8 pixels wide, selected by a bar counter (no divider). Left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Pattern 1, gradient: pixel = {x_cnt[4:0], y_cnt[5:0], x_cnt[4:0]}.
  - Pattern 2: pixel = pix_data sampled at the phase-0 edge of each pixel.
  - Pattern 3, external stream:
    - pix_req=1 in the cycle before each phase-0 cycle: the last VBP cycle, the last HBLANK cycle of non-final lines, and LINE phase-1 cycles except for the last pixel.
    - pix_data is captured on the clock edge that starts phase 0. The source must present the pixel in the cycle after pix_req (one-cycle latency).
    - There is no back-pressure; the source must always supply data.
  - pix_req=0 for patterns 0–2.
- Counter widths: x_cnt, y_cnt and the state timer are 16 bits.

Test Plan:
- Timing, pattern 0, test parameters H_PIXEL=8, V_PIXEL=4, VSYNC_LEN=3, V_BP=2, H_BLANK=4, V_FP=2, en held 1:
  - vsync high 3 cycles; first href 2 cycles after vsync falls.
  - 4 href pulses of 16 cycles, each followed by 4 blank cycles.
  - frame_done 87 cycles after VSYNC entry; next vsync on the following cycle.
- Colour bars, same parameters: line bytes are FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00; identical on all 4 lines.
- External stream, pattern 3: source returns 16'hA000+k for the k-th request.
  - 8 pix_req per line.
  - Line bytes are A0,00,A0,01,…,A0,07.
  - No pix_req during VFP or VSYNC.
- Mode change: pattern_sel changed 0→1 mid-frame with en dropped mid-frame.
  - The current frame finishes with colour bars.
  - frame_done pulses; FSM goes to IDLE; busy=0; no further vsync.
- Reset mid-line: rst_n low during line 2, byte 5.
  - Next edge: all outputs 0, busy=0, no frame_done.
  - After release with en=1: a fresh frame starts with vsync, and line 0 data starts at x=0.
- Gradient, pattern 1: line 3, pixel 5 reads {5'd5, 6'd3, 5'd5} = 16'h2865, i.e. bytes 28,65.
